// File: rtl/pipe_stall_ctrl_if.sv
// Hazard stall bundle between the hazard controller / EX stage and the stall controller.
// master drives the requests; slave is the controller that produces the enables and flushes.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             PCStall;
    logic             Redirect;
    logic             HaltReq;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXFlush;
    logic             Stalled;
    logic             Timeout;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output PCStall, Redirect, HaltReq,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Stalled, Timeout, StallCount
    );

    modport slave (
        input  PCStall, Redirect, HaltReq,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Stalled, Timeout, StallCount
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: turns stall, redirect and halt requests into PC/IF/ID/EX
// register enables, with a stall watchdog and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
    parameter int MAX_STALL    = 8,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic               clock,
    input  logic               reset,
    pipe_stall_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_RUN,
        S_STALL,
        S_RELEASE,
        S_FLUSH,
        S_HALT
    } state_t;

    state_t           r_state;
    logic [7:0]       r_runLen;
    logic [2:0]       r_flushCnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stallCount;

    state_t           w_nextState;
    logic [7:0]       w_runLenNext;
    logic [7:0]       w_runLenInc;
    logic [2:0]       w_flushCntNext;
    logic             w_setTimeout;
    logic             w_pcWrite;
    logic             w_ifidWrite;
    logic             w_ifidFlush;
    logic             w_idexFlush;
    logic             w_stalled;

    assign w_runLenInc = r_runLen + 8'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_RUN;
            r_runLen     <= '0;
            r_flushCnt   <= '0;
            r_timeout    <= 1'b0;
            r_stallCount <= '0;
        end else begin
            r_state    <= w_nextState;
            r_runLen   <= w_runLenNext;
            r_flushCnt <= w_flushCntNext;
            if (w_setTimeout) begin
                r_timeout <= 1'b1;
            end
            if (w_stalled && (r_stallCount != {CNT_W{1'b1}})) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_runLenNext   = r_runLen;
        w_flushCntNext = r_flushCnt;
        w_setTimeout   = 1'b0;
        w_pcWrite      = 1'b0;
        w_ifidWrite    = 1'b0;
        w_ifidFlush    = 1'b0;
        w_idexFlush    = 1'b0;
        w_stalled      = 1'b0;

        // A redirect wins in every state except HALT, and looks the same everywhere it is honoured.
        if ((r_state != S_HALT) && bus.Redirect) begin
            w_pcWrite    = 1'b1;
            w_ifidWrite  = 1'b1;
            w_ifidFlush  = 1'b1;
            w_idexFlush  = 1'b1;
            w_runLenNext = '0;
            if (FLUSH_CYCLES > 0) begin
                w_nextState    = S_FLUSH;
                w_flushCntNext = 3'(FLUSH_CYCLES);
            end else begin
                w_nextState    = S_RUN;
                w_flushCntNext = '0;
            end
        end else begin
            case (r_state)
                S_RUN, S_STALL: begin
                    if (bus.HaltReq) begin
                        w_idexFlush = 1'b1;
                        w_stalled   = 1'b1;
                        w_nextState = S_HALT;
                    end else if (bus.PCStall) begin
                        w_idexFlush = 1'b1;
                        w_stalled   = 1'b1;
                        if (w_runLenInc == 8'(MAX_STALL)) begin
                            w_nextState  = S_RELEASE;
                            w_setTimeout = 1'b1;
                            w_runLenNext = '0;
                        end else begin
                            w_nextState  = S_STALL;
                            w_runLenNext = w_runLenInc;
                        end
                    end else begin
                        w_pcWrite    = 1'b1;
                        w_ifidWrite  = 1'b1;
                        w_nextState  = S_RUN;
                        w_runLenNext = '0;
                    end
                end
                S_RELEASE: begin
                    w_pcWrite    = 1'b1;
                    w_ifidWrite  = 1'b1;
                    w_nextState  = S_RUN;
                    w_runLenNext = '0;
                end
                S_FLUSH: begin
                    w_pcWrite   = 1'b1;
                    w_ifidWrite = 1'b1;
                    w_ifidFlush = 1'b1;
                    if (r_flushCnt <= 3'd1) begin
                        w_nextState    = S_RUN;
                        w_flushCntNext = '0;
                    end else begin
                        w_flushCntNext = r_flushCnt - 3'd1;
                    end
                end
                S_HALT: begin
                    w_idexFlush = 1'b1;
                    w_stalled   = 1'b1;
                end
                default: begin
                    w_nextState = S_RUN;
                end
            endcase
        end

        // Reset overrides the Mealy outputs immediately, without waiting for an edge.
        if (!reset) begin
            w_pcWrite   = 1'b0;
            w_ifidWrite = 1'b0;
            w_ifidFlush = 1'b1;
            w_idexFlush = 1'b1;
            w_stalled   = 1'b0;
        end
    end

    assign bus.PCWrite    = w_pcWrite;
    assign bus.IFIDWrite  = w_ifidWrite;
    assign bus.IFIDFlush  = w_ifidFlush;
    assign bus.IDEXFlush  = w_idexFlush;
    assign bus.Stalled    = w_stalled;
    assign bus.Timeout    = r_timeout;
    assign bus.StallCount = r_stallCount;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a vector table for single-cycle decode plus
// hand-written sequences for the watchdog, halt, async reset and counter saturation.
module tb_pipe_stall_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clock = ~clock;

    pipe_stall_ctrl_if #(.CNT_W(16)) busA();
    pipe_stall_ctrl_if #(.CNT_W(4))  busB();

    pipe_stall_ctrl #(.MAX_STALL(8), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (busA)
    );

    pipe_stall_ctrl #(.MAX_STALL(255), .FLUSH_CYCLES(1), .CNT_W(4)) u_sat (
        .clock (clock),
        .reset (reset),
        .bus   (busB)
    );

    // Flags are packed as {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Stalled, Timeout}.
    typedef struct {
        logic        redirect;
        logic        pcStall;
        logic        haltReq;
        logic [5:0]  expFlags;
        logic [15:0] expCount;
    } vec_t;

    localparam logic [5:0] RESET_FLAGS = 6'b001100;

    vec_t vecs[12];

    function automatic logic [5:0] flagsA();
        return {busA.PCWrite, busA.IFIDWrite, busA.IFIDFlush, busA.IDEXFlush, busA.Stalled, busA.Timeout};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic redirect, input logic pcStall, input logic haltReq);
        @(negedge clock);
        busA.Redirect = redirect;
        busA.PCStall  = pcStall;
        busA.HaltReq  = haltReq;
        #1;
    endtask

    task automatic doReset(input string tag);
        @(negedge clock);
        reset = 1'b0;
        busA.Redirect = 1'b0;
        busA.PCStall  = 1'b0;
        busA.HaltReq  = 1'b0;
        busB.PCStall  = 1'b0;
        #1;
        checkOutput({tag, " reset flags"}, 32'(flagsA()), 32'(RESET_FLAGS));
        checkOutput({tag, " reset count"}, 32'(busA.StallCount), 32'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        busA.Redirect = 1'b0;
        busA.PCStall  = 1'b0;
        busA.HaltReq  = 1'b0;
        busB.Redirect = 1'b0;
        busB.PCStall  = 1'b0;
        busB.HaltReq  = 1'b0;

        //               redir stall halt   flags      count
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 6'b110000, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 6'b000110, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 6'b000110, 16'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 6'b000110, 16'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 6'b110000, 16'd3};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 6'b111100, 16'd3};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 6'b111000, 16'd3};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 6'b000110, 16'd3};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 6'b111100, 16'd4};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 6'b111100, 16'd4};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 6'b111000, 16'd4};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 6'b110000, 16'd4};

        // Single-cycle decode table: stalls, redirect over stall, flush, redirect inside flush.
        doReset("table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].redirect, vecs[i].pcStall, vecs[i].haltReq);
            checkOutput($sformatf("vec%0d flags", i), 32'(flagsA()), 32'(vecs[i].expFlags));
            checkOutput($sformatf("vec%0d count", i), 32'(busA.StallCount), 32'(vecs[i].expCount));
        end

        // Stall held 20 cycles: watchdog releases on cycles 9 and 18.
        doReset("watchdog");
        for (int c = 1; c <= 20; c++) begin
            logic       rel;
            logic       to;
            logic [5:0] exp;
            rel = (c == 9) || (c == 18);
            to  = (c >= 9);
            exp = rel ? {5'b11000, to} : {5'b00011, to};
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("watchdog cycle%0d flags", c), 32'(flagsA()), 32'(exp));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("watchdog after flags", 32'(flagsA()), 32'(6'b110001));
        checkOutput("watchdog after count", 32'(busA.StallCount), 32'd18);

        // Halt is terminal: redirect/stall/halt toggling has no effect.
        doReset("halt");
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("halt entry flags", 32'(flagsA()), 32'(6'b000110));
        for (int c = 0; c < 10; c++) begin
            applyStimulus(c[0], ~c[0], c[1]);
            checkOutput($sformatf("halt cycle%0d flags", c), 32'(flagsA()), 32'(6'b000110));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("halt count", 32'(busA.StallCount), 32'd11);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async reset flags", 32'(flagsA()), 32'(RESET_FLAGS));
        checkOutput("async reset count", 32'(busA.StallCount), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Narrow counter must saturate at 15 rather than wrap.
        doReset("saturate");
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            busB.PCStall = 1'b1;
            #1;
            checkOutput($sformatf("sat cycle%0d stalled", c), 32'(busB.Stalled), 32'd1);
            if (c == 16) begin
                checkOutput("sat count at 15 edges", 32'(busB.StallCount), 32'd15);
            end
        end
        @(negedge clock);
        busB.PCStall = 1'b0;
        #1;
        checkOutput("sat final count", 32'(busB.StallCount), 32'd15);
        checkOutput("sat timeout", 32'(busB.Timeout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
